// File: rtl/cv32e40p_x_result_buffer_pkg.sv
// cv32e40p_x_result_buffer_pkg: default sizes and entry layout for the X-interface result buffer
//   X_RESULT_DEPTH      default number of buffered result entries
//   X_STARVE_LIMIT      default cycles the buffer defers to ALU writebacks before forcing the port
//   X_ID_WIDTH_DEFAULT  default X-interface instruction id width
//   x_result_entry_t    {id, data, rd} entry at the default id width
package cv32e40p_x_result_buffer_pkg;

    localparam int X_RESULT_DEPTH     = 2;
    localparam int X_STARVE_LIMIT     = 4;
    localparam int X_ID_WIDTH_DEFAULT = 4;

    typedef struct packed {
        logic [X_ID_WIDTH_DEFAULT-1:0] id;
        logic [31:0]                   data;
        logic [4:0]                    rd;
    } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_buffer.sv
// cv32e40p_x_result_buffer: FIFO of coprocessor results sharing the EX regfile write port with ALU writebacks
//   x_result_valid_i/ready_o, id/data/rd/we_i  : coprocessor result beat handshake
//   alu_wb_req_i                               : EX wants the shared write port this cycle
//   x_result_valid_assigned_o, id/data/rd/we_o : head entry granted onto the write port
//   rs_addr_i/rs_hazard_o                      : ID-stage lookup of pending buffered writes
//   count_o                                    : occupied entries
module cv32e40p_x_result_buffer
    import cv32e40p_x_result_buffer_pkg::*;
#(
    parameter int DEPTH        = X_RESULT_DEPTH,
    parameter int STARVE_LIMIT = X_STARVE_LIMIT,
    parameter int X_ID_WIDTH   = X_ID_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_result_valid_i,
    output logic                         x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]        x_result_id_i,
    input  logic [31:0]                  x_result_data_i,
    input  logic [4:0]                   x_result_rd_i,
    input  logic                         x_result_we_i,
    input  logic                         alu_wb_req_i,
    output logic                         x_result_valid_assigned_o,
    output logic [X_ID_WIDTH-1:0]        x_result_id_o,
    output logic [31:0]                  x_result_data_o,
    output logic [4:0]                   x_result_rd_o,
    output logic                         x_result_we_o,
    input  logic [14:0]                  rs_addr_i,
    output logic [2:0]                   rs_hazard_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             ready, push, empty, grant, beat_wr;
    entry_t           head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // ready depends on registered occupancy only; held low while reset is asserted
    assign ready   = !rst && count_q < CW'(DEPTH);
    assign beat_wr = x_result_we_i && x_result_rd_i != 5'd0;
    assign push    = x_result_valid_i && ready && beat_wr;
    assign empty   = count_q == '0;
    assign grant   = !empty && (!alu_wb_req_i || starve_q == SW'(STARVE_LIMIT) || count_q == CW'(DEPTH));
    assign head    = mem_q[rd_ptr_q];

    assign x_result_ready_o          = ready;
    assign x_result_valid_assigned_o = grant;
    assign x_result_id_o             = grant ? head.id : '0;
    assign x_result_data_o           = grant ? head.data : '0;
    assign x_result_rd_o             = grant ? head.rd : '0;
    assign x_result_we_o             = grant;
    assign count_o                   = count_q;

    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{id: x_result_id_i, data: x_result_data_i, rd: x_result_rd_i};
            vld_d[wr_ptr_q] = 1'b1;
        end
        // push never targets the head slot while it is occupied, so clearing it here is safe
        if (grant)
            vld_d[rd_ptr_q] = 1'b0;
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = grant ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(grant);
        starve_d = (empty || grant) ? '0 : starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1;
    end

    always_comb begin
        rs_hazard_o = '0;
        for (int i = 0; i < 3; i++) begin
            rs_hazard_o[i] = x_result_valid_i && ready && x_result_we_i
                             && x_result_rd_i == rs_addr_i[5*i +: 5];
            for (int j = 0; j < DEPTH; j++)
                if (vld_q[j] && mem_q[j].rd == rs_addr_i[5*i +: 5])
                    rs_hazard_o[i] = 1'b1;
            if (rs_addr_i[5*i +: 5] == 5'd0)
                rs_hazard_o[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                mem_q[j] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_result_buffer.sv
// tb_cv32e40p_x_result_buffer: directed self-checking bench for cv32e40p_x_result_buffer
module tb_cv32e40p_x_result_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_result_valid_i = 1'b0;
    logic        x_result_ready_o;
    logic [3:0]  x_result_id_i = '0;
    logic [31:0] x_result_data_i = '0;
    logic [4:0]  x_result_rd_i = '0;
    logic        x_result_we_i = 1'b0;
    logic        alu_wb_req_i = 1'b0;
    logic        x_result_valid_assigned_o;
    logic [3:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic [14:0] rs_addr_i = '0;
    logic [2:0]  rs_hazard_o;
    logic [1:0]  count_o;

    int vectors = 0;
    int miscompares = 0;

    cv32e40p_x_result_buffer dut (
        .clk                       (clk),
        .rst                       (rst),
        .x_result_valid_i          (x_result_valid_i),
        .x_result_ready_o          (x_result_ready_o),
        .x_result_id_i             (x_result_id_i),
        .x_result_data_i           (x_result_data_i),
        .x_result_rd_i             (x_result_rd_i),
        .x_result_we_i             (x_result_we_i),
        .alu_wb_req_i              (alu_wb_req_i),
        .x_result_valid_assigned_o (x_result_valid_assigned_o),
        .x_result_id_o             (x_result_id_o),
        .x_result_data_o           (x_result_data_o),
        .x_result_rd_o             (x_result_rd_o),
        .x_result_we_o             (x_result_we_o),
        .rs_addr_i                 (rs_addr_i),
        .rs_hazard_o               (rs_hazard_o),
        .count_o                   (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd, input logic we);
        x_result_valid_i = 1'b1;
        x_result_id_i    = id;
        x_result_data_i  = data;
        x_result_rd_i    = rd;
        x_result_we_i    = we;
    endtask

    task automatic idle();
        x_result_valid_i = 1'b0;
        x_result_id_i    = '0;
        x_result_data_i  = '0;
        x_result_rd_i    = '0;
        x_result_we_i    = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(x_result_ready_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_grant", 32'(x_result_valid_assigned_o), 32'd0);
        chk("rst_data", x_result_data_o, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(x_result_ready_o), 32'd1);

        // single beat, no ALU contention
        beat(4'd1, 32'hDEADBEEF, 5'd5, 1'b1);
        rs_addr_i = {5'd0, 5'd0, 5'd5};
        #1;
        chk("beat_hazard", 32'(rs_hazard_o), 32'b001);
        chk("no_bypass", 32'(x_result_valid_assigned_o), 32'd0);
        tick();
        idle();
        rs_addr_i = '0;
        #1;
        chk("single_count", 32'(count_o), 32'd1);
        chk("single_grant", 32'(x_result_valid_assigned_o), 32'd1);
        chk("single_rd", 32'(x_result_rd_o), 32'd5);
        chk("single_data", x_result_data_o, 32'hDEADBEEF);
        chk("single_id", 32'(x_result_id_o), 32'd1);
        chk("single_we", 32'(x_result_we_o), 32'd1);
        tick();
        chk("single_drain", 32'(count_o), 32'd0);
        chk("single_idle_grant", 32'(x_result_valid_assigned_o), 32'd0);
        chk("single_idle_data", x_result_data_o, 32'd0);

        // beats that do not write are dropped
        beat(4'd2, 32'h1111, 5'd0, 1'b1);
        #1;
        chk("rd0_ready", 32'(x_result_ready_o), 32'd1);
        tick();
        chk("rd0_count", 32'(count_o), 32'd0);
        chk("rd0_grant", 32'(x_result_valid_assigned_o), 32'd0);
        beat(4'd3, 32'h2222, 5'd9, 1'b0);
        rs_addr_i = {5'd0, 5'd0, 5'd9};
        #1;
        chk("we0_hazard", 32'(rs_hazard_o), 32'd0);
        tick();
        idle();
        #1;
        chk("we0_count", 32'(count_o), 32'd0);
        chk("we0_grant", 32'(x_result_valid_assigned_o), 32'd0);
        chk("we0_ready", 32'(x_result_ready_o), 32'd1);

        // starvation: defer 4 cycles, forced on the 5th
        alu_wb_req_i = 1'b1;
        beat(4'd3, 32'hCAFE0003, 5'd6, 1'b1);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("starve_defer", 32'(x_result_valid_assigned_o), 32'd0);
            tick();
        end
        chk("starve_force", 32'(x_result_valid_assigned_o), 32'd1);
        chk("starve_rd", 32'(x_result_rd_o), 32'd6);
        chk("starve_data", x_result_data_o, 32'hCAFE0003);
        tick();
        chk("starve_drain", 32'(count_o), 32'd0);
        beat(4'd4, 32'h4, 5'd8, 1'b1);
        tick();
        idle();
        chk("starve_cleared", 32'(x_result_valid_assigned_o), 32'd0);
        alu_wb_req_i = 1'b0;
        #1;
        chk("alu_free_grant", 32'(x_result_valid_assigned_o), 32'd1);
        chk("alu_free_id", 32'(x_result_id_o), 32'd4);
        tick();
        chk("alu_free_drain", 32'(count_o), 32'd0);

        // back-to-back beats fill the buffer, full forces the port
        alu_wb_req_i = 1'b1;
        beat(4'd1, 32'hA1, 5'd10, 1'b1);
        tick();
        chk("fill_count1", 32'(count_o), 32'd1);
        chk("fill_defer", 32'(x_result_valid_assigned_o), 32'd0);
        beat(4'd2, 32'hA2, 5'd11, 1'b1);
        tick();
        idle();
        chk("full_count", 32'(count_o), 32'd2);
        chk("full_ready", 32'(x_result_ready_o), 32'd0);
        chk("full_force", 32'(x_result_valid_assigned_o), 32'd1);
        chk("full_head_id", 32'(x_result_id_o), 32'd1);
        tick();
        chk("after_pop_count", 32'(count_o), 32'd1);
        chk("after_pop_ready", 32'(x_result_ready_o), 32'd1);
        chk("after_pop_defer", 32'(x_result_valid_assigned_o), 32'd0);
        alu_wb_req_i = 1'b0;
        #1;
        chk("second_grant", 32'(x_result_valid_assigned_o), 32'd1);
        chk("second_id", 32'(x_result_id_o), 32'd2);
        chk("second_rd", 32'(x_result_rd_o), 32'd11);
        tick();
        chk("fill_drain", 32'(count_o), 32'd0);

        // hazard lookup on a buffered entry
        alu_wb_req_i = 1'b1;
        beat(4'd5, 32'h77, 5'd7, 1'b1);
        tick();
        idle();
        rs_addr_i = {5'd0, 5'd7, 5'd3};
        #1;
        chk("hazard_pending", 32'(rs_hazard_o), 32'b010);
        alu_wb_req_i = 1'b0;
        tick();
        chk("hazard_cleared", 32'(rs_hazard_o), 32'b000);
        rs_addr_i = '0;

        // reset with two buffered entries
        alu_wb_req_i = 1'b1;
        beat(4'd6, 32'hB6, 5'd12, 1'b1);
        tick();
        beat(4'd7, 32'hB7, 5'd13, 1'b1);
        tick();
        idle();
        chk("pre_reset_count", 32'(count_o), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_reset_count", 32'(count_o), 32'd0);
        chk("mid_reset_grant", 32'(x_result_valid_assigned_o), 32'd0);
        chk("mid_reset_ready", 32'(x_result_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        alu_wb_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("no_stale_grant", 32'(x_result_valid_assigned_o), 32'd0);
            chk("no_stale_count", 32'(count_o), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
